pipe_ctrl_unit: RTL and testbench



---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_decode.sv | 68 ++++++
 rtl/pipe_ctrl_unit.sv | 136 +++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the LEGv8 ID-stage control unit.
//   - opcode match patterns (value + care-mask, 11-bit instr[31:21])
//   - aluop_e  : ALU operation codes
//   - ctrl_t   : ID/EX control bundle
//   - state_e  : issue FSM states
//   - opc_hit  : masked opcode compare
//   - reads_b  : whether a decoded instruction reads its second register
package ctrl_pkg;

    // Pattern/mask pairs; a 0 in the mask marks a don't-care opcode bit
    localparam logic [10:0] OPC_ADDI = 11'b10010001000;
    localparam logic [10:0] MSK_ADDI = 11'b11111111110;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_B    = 11'b00010100000;
    localparam logic [10:0] MSK_B    = 11'b11111100000;
    localparam logic [10:0] OPC_BLT  = 11'b01010100000;
    localparam logic [10:0] OPC_CBZ  = 11'b10110100000;
    localparam logic [10:0] MSK_CB   = 11'b11111111000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_LSL  = 11'b11010011011;
    localparam logic [10:0] OPC_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC_MUL  = 11'b10011011000;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] MSK_ALL  = 11'b11111111111;

    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_SHIFT = 3'b001,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_MUL   = 3'b111
    } aluop_e;

    typedef struct packed {
        logic   reg2loc;
        logic   ubranch;
        logic   branch;
        logic   memread;
        logic   memtoreg;
        aluop_e aluop;
        logic   memwrite;
        logic   alusrc;
        logic   regwrite;
        logic   shiftdir;   // 0 = left, 1 = right
        logic   flagen;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    function automatic logic opc_hit(input logic [10:0] opc,
                                     input logic [10:0] val,
                                     input logic [10:0] msk);
        return (opc & msk) == val;
    endfunction

    // Register-register ALU ops (no immediate, writes back) and the
    // reg2loc forms (STUR, CBZ) are the only ones that read Rm/Rt.
    function automatic logic reads_b(input ctrl_t c);
        return c.reg2loc | (~c.alusrc & c.regwrite);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode -> ctrl_t decoder.
// Ports:
//   opcode : instr[31:21]
//   ctrl   : decoded control bundle (all don't-care fields 0)
//   match  : 1 when opcode is one of the supported instructions
module ctrl_decode import ctrl_pkg::*; #(
    parameter int OPC_W = 11
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl,
    output logic             match
);

    logic [10:0] opc;
    assign opc = 11'(opcode);

    always_comb begin
        ctrl  = '0;
        match = 1'b1;
        if (opc_hit(opc, OPC_ADDI, MSK_ADDI)) begin
            ctrl.aluop    = ALU_ADD;
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
        end else if (opc_hit(opc, OPC_ADDS, MSK_ALL)) begin
            ctrl.aluop    = ALU_ADD;
            ctrl.regwrite = 1'b1;
            ctrl.flagen   = 1'b1;
        end else if (opc_hit(opc, OPC_SUBS, MSK_ALL)) begin
            ctrl.aluop    = ALU_SUB;
            ctrl.regwrite = 1'b1;
            ctrl.flagen   = 1'b1;
        end else if (opc_hit(opc, OPC_B, MSK_B)) begin
            ctrl.ubranch  = 1'b1;
        end else if (opc_hit(opc, OPC_BLT, MSK_CB)) begin
            ctrl.branch   = 1'b1;
        end else if (opc_hit(opc, OPC_CBZ, MSK_CB)) begin
            ctrl.reg2loc  = 1'b1;
            ctrl.branch   = 1'b1;
            ctrl.aluop    = ALU_PASSB;
        end else if (opc_hit(opc, OPC_LDUR, MSK_ALL)) begin
            ctrl.memread  = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.aluop    = ALU_ADD;
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
        end else if (opc_hit(opc, OPC_STUR, MSK_ALL)) begin
            ctrl.reg2loc  = 1'b1;
            ctrl.aluop    = ALU_ADD;
            ctrl.memwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
        end else if (opc_hit(opc, OPC_LSL, MSK_ALL)) begin
            ctrl.aluop    = ALU_SHIFT;
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
        end else if (opc_hit(opc, OPC_LSR, MSK_ALL)) begin
            ctrl.aluop    = ALU_SHIFT;
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.shiftdir = 1'b1;
        end else if (opc_hit(opc, OPC_MUL, MSK_ALL)) begin
            ctrl.aluop    = ALU_MUL;
            ctrl.regwrite = 1'b1;
        end else begin
            match = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: LEGv8 ID-stage control unit. Decodes the IF/ID opcode,
// registers the ID/EX control bundle, detects load-use hazards, holds the
// front end during multi-cycle MUL and honours EX branch flushes.
// Issue priority: flush > MUL busy > load-use hazard > normal issue.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unmatched opcodes set the
// sticky illegal flag and issue a bubble; otherwise they issue as a NOP).
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   instr_valid   : IF/ID holds a valid instruction
//   opcode        : instr[31:21]
//   src_a, src_b  : Rn, Rm/Rt (after Reg2Loc)
//   dst           : Rd/Rt
//   branch_taken  : EX taken branch, flushes the issuing slot
//   stall         : hold PC and IF/ID this cycle (combinational)
//   ctrl_q        : registered ID/EX control bundle
//   ctrl_valid    : ctrl_q is a real instruction
//   dst_q         : registered destination register
//   illegal       : sticky undecodable-opcode flag
module pipe_ctrl_unit import ctrl_pkg::*; #(
    parameter int OPC_W   = 11,
    parameter int RA_W    = 5,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [OPC_W-1:0] opcode,
    input  logic [RA_W-1:0]  src_a,
    input  logic [RA_W-1:0]  src_b,
    input  logic [RA_W-1:0]  dst,
    input  logic             branch_taken,
    output logic             stall,
    output ctrl_t            ctrl_q,
    output logic             ctrl_valid,
    output logic [RA_W-1:0]  dst_q,
    output logic             illegal
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    ctrl_t            dec_ctrl;
    logic             dec_match;
    logic             hazard;
    state_e           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    ctrl_t            ctrl_n;
    logic             vld_n;
    logic [RA_W-1:0]  dst_n;

    ctrl_decode #(.OPC_W(OPC_W)) u_dec (
        .opcode (opcode),
        .ctrl   (dec_ctrl),
        .match  (dec_match)
    );

    // X31 is XZR: a load targeting it never creates a dependency
    assign hazard = instr_valid && ctrl_valid && ctrl_q.memread &&
                    (dst_q != RA_W'(31)) &&
                    ((dst_q == src_a) || (reads_b(dec_ctrl) && (dst_q == src_b)));

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_n;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ctrl_n  = '0;
        vld_n   = 1'b0;
        dst_n   = '0;
        stall   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_n = illegal_q;
`endif
        if (branch_taken) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (state_q == ST_MUL_BUSY) begin
            stall = 1'b1;
            cnt_n = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_n = ST_IDLE;
            end
        end else if (hazard) begin
            stall = 1'b1;
        end else if (instr_valid) begin
            if (dec_match) begin
                ctrl_n = dec_ctrl;
                vld_n  = 1'b1;
                dst_n  = dst;
                if ((dec_ctrl.aluop == ALU_MUL) && (MUL_LAT > 1)) begin
                    state_n = ST_MUL_BUSY;
                    cnt_n   = CNT_W'(MUL_LAT - 1);
                end
            end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegal_n = 1'b1;
`else
                vld_n = 1'b1;
                dst_n = dst;
`endif
            end
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            ctrl_valid <= 1'b0;
            dst_q      <= '0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            ctrl_q     <= ctrl_n;
            ctrl_valid <= vld_n;
            dst_q      <= dst_n;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_n;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed self-checking bench for pipe_ctrl_unit
// (default parameters: OPC_W=11, RA_W=5, MUL_LAT=3).
// Inputs change 1 time unit after the rising edge; registered outputs are
// checked there, combinational stall 1 unit after the inputs change.
module tb_pipe_ctrl_unit;
    import ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [10:0] opcode;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [4:0]  dst;
    logic        branch_taken;
    logic        stall;
    ctrl_t       ctrl_q;
    logic        ctrl_valid;
    logic [4:0]  dst_q;
    logic        illegal;
    logic [12:0] cq;

    int errors = 0;
    int checks = 0;

    // Hand-encoded opcodes
    localparam logic [10:0] ADDI0 = 11'b10010001000;
    localparam logic [10:0] ADDI1 = 11'b10010001001;
    localparam logic [10:0] SUBS  = 11'b11101011000;
    localparam logic [10:0] ADDS  = 11'b10101011000;
    localparam logic [10:0] LDUR  = 11'b11111000010;
    localparam logic [10:0] MUL   = 11'b10011011000;

    // Expected bundles: {reg2loc,ubranch,branch,memread,memtoreg,aluop[2:0],
    //                    memwrite,alusrc,regwrite,shiftdir,flagen}
    localparam logic [12:0] E_ADDI = 13'b0000001001100;
    localparam logic [12:0] E_SUBS = 13'b0000001100101;
    localparam logic [12:0] E_ADDS = 13'b0000001000101;
    localparam logic [12:0] E_LDUR = 13'b0001101001100;
    localparam logic [12:0] E_MUL  = 13'b0000011100100;

    assign cq = ctrl_q;

    pipe_ctrl_unit dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .src_a        (src_a),
        .src_b        (src_b),
        .dst          (dst),
        .branch_taken (branch_taken),
        .stall        (stall),
        .ctrl_q       (ctrl_q),
        .ctrl_valid   (ctrl_valid),
        .dst_q        (dst_q),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [10:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic bt);
        instr_valid  = v;
        opcode       = op;
        src_a        = a;
        src_b        = b;
        dst          = d;
        branch_taken = bt;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick;
        tick;
        checks++; if (cq !== 13'd0) begin errors++; $display("FAIL reset_ctrl: got %b want %b", cq, 13'd0); end
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ctrl_valid); end
        checks++; if (dst_q !== 5'd0) begin errors++; $display("FAIL reset_dst: got %0d want 0", dst_q); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        reset = 1'b0;
    endtask

    task automatic test_decode;
        logic [10:0] opc_tab [10];
        logic [12:0] exp_tab [10];
        opc_tab[0] = ADDI0;          exp_tab[0] = E_ADDI;
        opc_tab[1] = ADDI1;          exp_tab[1] = E_ADDI;
        opc_tab[2] = SUBS;           exp_tab[2] = E_SUBS;
        opc_tab[3] = ADDS;           exp_tab[3] = E_ADDS;
        opc_tab[4] = 11'b11010011011; exp_tab[4] = 13'b0000000101100; // LSL
        opc_tab[5] = 11'b11010011010; exp_tab[5] = 13'b0000000101110; // LSR
        opc_tab[6] = 11'b11111000000; exp_tab[6] = 13'b1000001011000; // STUR
        opc_tab[7] = 11'b00010110101; exp_tab[7] = 13'b0100000000000; // B
        opc_tab[8] = 11'b01010100011; exp_tab[8] = 13'b0010000000000; // BLT
        opc_tab[9] = 11'b10110100110; exp_tab[9] = 13'b1010000000000; // CBZ
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, opc_tab[i], 5'd1, 5'd2, 5'(i + 3), 1'b0);
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dec_stall[%0d]: got %b want 0", i, stall); end
            tick;
            checks++; if (cq !== exp_tab[i]) begin errors++; $display("FAIL dec_ctrl[%0d]: got %b want %b", i, cq, exp_tab[i]); end
            checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL dec_valid[%0d]: got %b want 1", i, ctrl_valid); end
            checks++; if (dst_q !== 5'(i + 3)) begin errors++; $display("FAIL dec_dst[%0d]: got %0d want %0d", i, dst_q, i + 3); end
        end
    endtask

    task automatic test_load_use;
        // Rn dependency
        drive(1'b1, LDUR, 5'd1, 5'd2, 5'd5, 1'b0);
        tick;
        checks++; if (cq !== E_LDUR) begin errors++; $display("FAIL lu_ldur: got %b want %b", cq, E_LDUR); end
        drive(1'b1, ADDS, 5'd5, 5'd2, 5'd6, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall); end
        tick;
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b want 0", ctrl_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %b want 0", stall); end
        tick;
        checks++; if (cq !== E_ADDS || ctrl_valid !== 1'b1) begin errors++; $display("FAIL lu_issue: got %b/%b want %b/1", cq, ctrl_valid, E_ADDS); end
        checks++; if (dst_q !== 5'd6) begin errors++; $display("FAIL lu_dst: got %0d want 6", dst_q); end
        // Rm dependency on an instruction that reads B
        drive(1'b1, LDUR, 5'd1, 5'd2, 5'd7, 1'b0);
        tick;
        drive(1'b1, ADDS, 5'd1, 5'd7, 5'd6, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_srcb_stall: got %b want 1", stall); end
        tick;
        tick;
        checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL lu_srcb_issue: got %b want 1", ctrl_valid); end
        // Immediate form does not read B: no hazard
        drive(1'b1, LDUR, 5'd1, 5'd2, 5'd7, 1'b0);
        tick;
        drive(1'b1, ADDI0, 5'd1, 5'd7, 5'd6, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_imm_nostall: got %b want 0", stall); end
        tick;
        checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL lu_imm_issue: got %b want 1", ctrl_valid); end
        // XZR destination: no hazard
        drive(1'b1, LDUR, 5'd1, 5'd2, 5'd31, 1'b0);
        tick;
        drive(1'b1, ADDS, 5'd31, 5'd31, 5'd6, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_xzr_stall: got %b want 0", stall); end
        tick;
        checks++; if (cq !== E_ADDS || ctrl_valid !== 1'b1) begin errors++; $display("FAIL lu_xzr_issue: got %b/%b want %b/1", cq, ctrl_valid, E_ADDS); end
        // No valid instruction: no hazard, bubble
        drive(1'b1, LDUR, 5'd1, 5'd2, 5'd5, 1'b0);
        tick;
        drive(1'b0, ADDS, 5'd5, 5'd5, 5'd6, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_invalid_stall: got %b want 0", stall); end
        tick;
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL lu_invalid_bubble: got %b want 0", ctrl_valid); end
    endtask

    task automatic test_mul;
        drive(1'b1, MUL, 5'd1, 5'd2, 5'd4, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_issue_stall: got %b want 0", stall); end
        tick;
        checks++; if (cq !== E_MUL || ctrl_valid !== 1'b1) begin errors++; $display("FAIL mul_issue: got %b/%b want %b/1", cq, ctrl_valid, E_MUL); end
        drive(1'b1, ADDI0, 5'd1, 5'd2, 5'd9, 1'b0);
        for (int c = 0; c < 2; c++) begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mul_stall[%0d]: got %b want 1", c, stall); end
            tick;
            checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL mul_bubble[%0d]: got %b want 0", c, ctrl_valid); end
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mul_release: got %b want 0", stall); end
        tick;
        checks++; if (cq !== E_ADDI || ctrl_valid !== 1'b1 || dst_q !== 5'd9) begin
            errors++; $display("FAIL mul_next: got %b/%b/%0d want %b/1/9", cq, ctrl_valid, dst_q, E_ADDI); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, MUL, 5'd1, 5'd2, 5'd4, 1'b0);
        tick;
        drive(1'b1, MUL, 5'd1, 5'd2, 5'd8, 1'b0);
        tick;
        tick;
        checks++; if (stall !== 1'b0 || ctrl_valid !== 1'b0) begin errors++; $display("FAIL b2b_wait: got stall %b valid %b want 0/0", stall, ctrl_valid); end
        tick;
        checks++; if (cq !== E_MUL || ctrl_valid !== 1'b1 || dst_q !== 5'd8) begin
            errors++; $display("FAIL b2b_second: got %b/%b/%0d want %b/1/8", cq, ctrl_valid, dst_q, E_MUL); end
        drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_busy_again: got %b want 1", stall); end
        tick;
        tick;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", stall); end
    endtask

    task automatic test_flush;
        drive(1'b1, MUL, 5'd1, 5'd2, 5'd4, 1'b0);
        tick;
        drive(1'b1, ADDI0, 5'd1, 5'd2, 5'd9, 1'b1);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick;
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ctrl_valid); end
        drive(1'b1, ADDI0, 5'd1, 5'd2, 5'd9, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b want 0", stall); end
        tick;
        checks++; if (cq !== E_ADDI || ctrl_valid !== 1'b1) begin errors++; $display("FAIL flush_next: got %b/%b want %b/1", cq, ctrl_valid, E_ADDI); end
    endtask

    task automatic test_illegal;
        drive(1'b1, 11'b00000000000, 5'd1, 5'd2, 5'd2, 1'b0);
        tick;
`ifdef CTRL_ILLEGAL_TRAP_EN
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_set: got %b want 1", illegal); end
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL ill_bubble: got %b want 0", ctrl_valid); end
        drive(1'b1, ADDI0, 5'd1, 5'd2, 5'd3, 1'b0);
        tick;
        tick;
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %b want 1", illegal); end
`else
        checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL nop_valid: got %b want 1", ctrl_valid); end
        checks++; if (cq !== 13'd0) begin errors++; $display("FAIL nop_ctrl: got %b want 0", cq); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL nop_illegal: got %b want 0", illegal); end
`endif
    endtask

    task automatic test_reset_mid_mul;
        drive(1'b1, MUL, 5'd1, 5'd2, 5'd4, 1'b0);
        tick;
        drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mul_busy: got %b want 1", stall); end
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mul_stall: got %b want 0", stall); end
        checks++; if (cq !== 13'd0 || ctrl_valid !== 1'b0 || dst_q !== 5'd0) begin
            errors++; $display("FAIL rst_mul_outs: got %b/%b/%0d want 0/0/0", cq, ctrl_valid, dst_q); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_mul_illegal: got %b want 0", illegal); end
        tick;
        reset = 1'b0;
        drive(1'b1, ADDI1, 5'd1, 5'd2, 5'd3, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_after_stall: got %b want 0", stall); end
        tick;
        checks++; if (cq !== E_ADDI || ctrl_valid !== 1'b1 || dst_q !== 5'd3) begin
            errors++; $display("FAIL rst_after_issue: got %b/%b/%0d want %b/1/3", cq, ctrl_valid, dst_q, E_ADDI); end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_load_use;
        test_mul;
        test_back_to_back;
        test_flush;
        test_illegal;
        test_reset_mid_mul;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
